// File: rtl/corr_metrics.sv
// corr_metrics: captures normalised window counts and computes covariance, dependency and Hamming metrics.
// Define CORR_METRICS_DEP_EN to include the iterative divider and the dependency metric.
module corr_metrics #(
    parameter int unsigned METRIC_PRECISION = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cg,
    input  logic [METRIC_PRECISION-1:0] i_countX,
    input  logic [METRIC_PRECISION-1:0] i_countY,
    input  logic [METRIC_PRECISION-1:0] i_countIsect,
    input  logic [METRIC_PRECISION-1:0] i_countSymdiff,
    input  logic                        i_valid,
    output logic                        o_busy,
    output logic                        o_overrun,
    output logic                        o_valid,
    output logic [METRIC_PRECISION-1:0] o_metricCov,
    output logic [METRIC_PRECISION-1:0] o_metricDep,
    output logic [METRIC_PRECISION-1:0] o_metricHam
);

    localparam int unsigned P  = METRIC_PRECISION;
    localparam int unsigned W2 = 2 * P;

`ifdef CORR_METRICS_DEP_EN
    localparam int unsigned CW = $clog2(P);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

    state_t       state;
    logic [P-1:0] x_r;
    logic [P-1:0] y_r;
    logic [P-1:0] isect_r;
    logic [P-1:0] symdiff_r;
    logic [P-1:0] prod_c;

    // Upper half of the 2P-bit product X*Y
    assign prod_c = P'((W2'(x_r) * W2'(y_r)) >> P);

    function automatic logic [P-1:0] abs_diff(input logic [P-1:0] a, input logic [P-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    // |isect - prod| scaled by 4, saturating when the shift would overflow
    function automatic logic [P-1:0] cov_of(input logic [P-1:0] isect, input logic [P-1:0] prod);
        logic [P-1:0] d;
        d = abs_diff(isect, prod);
        return (d[P-1] | d[P-2]) ? '1 : {d[P-3:0], 2'b00};
    endfunction

`ifdef CORR_METRICS_DEP_EN
    logic [P-1:0]  prod_r;
    logic [P-1:0]  rem;
    logic [P-2:0]  q;
    logic [CW-1:0] cnt;
    logic [P:0]    rem_sh;
    logic          ge;
    logic [P-1:0]  rem_next;
    logic [P-1:0]  q_next;
    logic [P-1:0]  q_final;

    // One restoring-division step; rem stays below Y since isect < Y in the normal case
    always_comb begin
        rem_sh   = {rem, 1'b0};
        ge       = (rem_sh >= {1'b0, y_r});
        rem_next = ge ? P'(rem_sh - {1'b0, y_r}) : rem_sh[P-1:0];
        q_next   = {q, ge};
        if (y_r == '0) begin
            q_final = '0;
        end else if (isect_r >= y_r) begin
            q_final = '1;
        end else begin
            q_final = q_next;
        end
    end
`else
    assign o_metricDep = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
            o_valid     <= 1'b0;
            o_metricCov <= '0;
            o_metricHam <= '0;
            x_r         <= '0;
            y_r         <= '0;
            isect_r     <= '0;
            symdiff_r   <= '0;
`ifdef CORR_METRICS_DEP_EN
            o_metricDep <= '0;
            prod_r      <= '0;
            rem         <= '0;
            q           <= '0;
            cnt         <= '0;
`endif
        end else if (i_cg) begin
            o_valid   <= 1'b0;
            o_overrun <= i_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        x_r       <= i_countX;
                        y_r       <= i_countY;
                        isect_r   <= i_countIsect;
                        symdiff_r <= i_countSymdiff;
                        o_busy    <= 1'b1;
                        state     <= MUL;
                    end
                end
                MUL: begin
`ifdef CORR_METRICS_DEP_EN
                    prod_r <= prod_c;
                    rem    <= isect_r;
                    q      <= '0;
                    cnt    <= CW'(P - 1);
                    state  <= DIV;
`else
                    o_metricCov <= cov_of(isect_r, prod_c);
                    o_metricHam <= ~symdiff_r;
                    o_valid     <= 1'b1;
                    state       <= DONE;
`endif
                end
`ifdef CORR_METRICS_DEP_EN
                DIV: begin
                    rem <= rem_next;
                    q   <= q_next[P-2:0];
                    cnt <= cnt - CW'(1);
                    // Last quotient bit resolves this cycle; publish all metrics together
                    if (cnt == '0) begin
                        o_metricCov <= cov_of(isect_r, prod_r);
                        o_metricDep <= abs_diff(q_final, x_r);
                        o_metricHam <= ~symdiff_r;
                        o_valid     <= 1'b1;
                        state       <= DONE;
                    end
                end
`endif
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corr_metrics.sv
// tb_corr_metrics: directed-vector bench for corr_metrics at P=8 (either CORR_METRICS_DEP_EN build).
module tb_corr_metrics;

    localparam int P = 8;
`ifdef CORR_METRICS_DEP_EN
    localparam bit DEP = 1'b1;
`else
    localparam bit DEP = 1'b0;
`endif
    localparam int LAT = DEP ? P + 2 : 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         cg;
    logic         vld;
    logic [P-1:0] cx, cy, cis, csd;
    logic         o_busy, o_overrun, o_valid;
    logic [P-1:0] o_metricCov, o_metricDep, o_metricHam;

    int n_cmp = 0;
    int n_err = 0;

    // Vectors: x, y, isect, symdiff -> cov, dep (divider build), ham
    logic [P-1:0] tx  [5] = '{8'h80, 8'h80, 8'h30, 8'h10, 8'hC0};
    logic [P-1:0] ty  [5] = '{8'h80, 8'h80, 8'h00, 8'h40, 8'hA0};
    logic [P-1:0] tis [5] = '{8'h40, 8'h80, 8'h00, 8'h20, 8'h70};
    logic [P-1:0] tsd [5] = '{8'h80, 8'h00, 8'h30, 8'h50, 8'h3A};
    logic [P-1:0] ecov[5] = '{8'h00, 8'hFF, 8'h00, 8'h70, 8'h20};
    logic [P-1:0] edep[5] = '{8'h00, 8'h7F, 8'h30, 8'h70, 8'h0D};
    logic [P-1:0] eham[5] = '{8'h7F, 8'hFF, 8'hCF, 8'hAF, 8'hC5};

    always #5 clk = ~clk;

    corr_metrics #(.METRIC_PRECISION(P)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cg          (cg),
        .i_countX      (cx),
        .i_countY      (cy),
        .i_countIsect  (cis),
        .i_countSymdiff(csd),
        .i_valid       (vld),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun),
        .o_valid       (o_valid),
        .o_metricCov   (o_metricCov),
        .o_metricDep   (o_metricDep),
        .o_metricHam   (o_metricHam)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i);
        cx  = tx[i];
        cy  = ty[i];
        cis = tis[i];
        csd = tsd[i];
    endtask

    function automatic logic [P-1:0] exp_dep(input int i);
        return DEP ? edep[i] : '0;
    endfunction

    // Pulse i_valid with vector i and wait (bounded) for o_valid; lat is the cycle it appeared in
    task automatic start_and_wait(input int i, output int lat);
        set_vec(i);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        lat = 1;
        while (o_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cg = 1'b1; vld = 1'b0; set_vec(0);
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", o_overrun); end
        n_cmp++; if (o_metricCov !== 8'h00) begin n_err++; $display("FAIL reset_cov: got %h expected 00", o_metricCov); end
        n_cmp++; if (o_metricDep !== 8'h00) begin n_err++; $display("FAIL reset_dep: got %h expected 00", o_metricDep); end
        n_cmp++; if (o_metricHam !== 8'h00) begin n_err++; $display("FAIL reset_ham: got %h expected 00", o_metricHam); end
    endtask

    task automatic test_metrics();
        int lat;
        for (int i = 0; i < 5; i++) begin
            start_and_wait(i, lat);
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL metrics_lat[%0d]: got %0d expected %0d", i, lat, LAT); end
            n_cmp++; if (o_metricCov !== ecov[i]) begin n_err++; $display("FAIL metrics_cov[%0d]: got %h expected %h", i, o_metricCov, ecov[i]); end
            n_cmp++; if (o_metricDep !== exp_dep(i)) begin n_err++; $display("FAIL metrics_dep[%0d]: got %h expected %h", i, o_metricDep, exp_dep(i)); end
            n_cmp++; if (o_metricHam !== eham[i]) begin n_err++; $display("FAIL metrics_ham[%0d]: got %h expected %h", i, o_metricHam, eham[i]); end
            n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL metrics_busy_done[%0d]: got %b expected 1", i, o_busy); end
            tick();
            n_cmp++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin n_err++; $display("FAIL metrics_idle[%0d]: got valid=%b busy=%b expected 0/0", i, o_valid, o_busy); end
        end
    endtask

    task automatic test_overrun();
        int nv = 0;
        int no = 0;
        int off = DEP ? 3 : 1;
        logic [P-1:0] cov = '0, ham = '0;
        set_vec(0);
        vld = 1'b1;
        tick();
        for (int c = 1; c < 30; c++) begin
            if (o_valid === 1'b1) begin nv++; cov = o_metricCov; ham = o_metricHam; end
            if (o_overrun === 1'b1) no++;
            vld = (c == off);
            if (c == off) set_vec(1);
            tick();
        end
        vld = 1'b0;
        n_cmp++; if (no !== 1) begin n_err++; $display("FAIL overrun_pulses: got %0d expected 1", no); end
        n_cmp++; if (nv !== 1) begin n_err++; $display("FAIL overrun_valids: got %0d expected 1", nv); end
        n_cmp++; if (cov !== ecov[0]) begin n_err++; $display("FAIL overrun_cov: got %h expected %h", cov, ecov[0]); end
        n_cmp++; if (ham !== eham[0]) begin n_err++; $display("FAIL overrun_ham: got %h expected %h", ham, eham[0]); end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        int lat;
        int mid = DEP ? 4 : 1;
        set_vec(1);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        for (int c = 1; c < mid; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", o_busy); end
        n_cmp++; if (o_metricCov !== 8'h00 || o_metricHam !== 8'h00 || o_metricDep !== 8'h00) begin
            n_err++; $display("FAIL midrst_outputs: got cov=%h dep=%h ham=%h expected 00/00/00", o_metricCov, o_metricDep, o_metricHam);
        end
        for (int c = 0; c < 15; c++) begin
            if (o_valid === 1'b1) nv++;
            tick();
        end
        n_cmp++; if (nv !== 0) begin n_err++; $display("FAIL midrst_no_valid: got %0d expected 0", nv); end
        start_and_wait(4, lat);
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL midrst_lat: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (o_metricCov !== ecov[4] || o_metricDep !== exp_dep(4) || o_metricHam !== eham[4]) begin
            n_err++; $display("FAIL midrst_result: got %h/%h/%h expected %h/%h/%h", o_metricCov, o_metricDep, o_metricHam, ecov[4], exp_dep(4), eham[4]);
        end
        tick();
    endtask

    task automatic test_clock_gate();
        int lat;
        int g0 = DEP ? 4 : 1;
        set_vec(3);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        lat = 1;
        while (o_valid !== 1'b1 && lat < 100) begin
            cg = !(lat >= g0 && lat < g0 + 5);
            tick();
            lat++;
        end
        cg = 1'b1;
        n_cmp++; if (lat !== LAT + 5) begin n_err++; $display("FAIL cg_lat: got %0d expected %0d", lat, LAT + 5); end
        n_cmp++; if (o_metricCov !== ecov[3] || o_metricDep !== exp_dep(3) || o_metricHam !== eham[3]) begin
            n_err++; $display("FAIL cg_result: got %h/%h/%h expected %h/%h/%h", o_metricCov, o_metricDep, o_metricHam, ecov[3], exp_dep(3), eham[3]);
        end
        cg = 1'b0;
        tick(); tick();
        n_cmp++; if (o_valid !== 1'b1 || o_busy !== 1'b1) begin n_err++; $display("FAIL cg_hold_pulse: got valid=%b busy=%b expected 1/1", o_valid, o_busy); end
        cg = 1'b1;
        tick();
        n_cmp++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin n_err++; $display("FAIL cg_release: got valid=%b busy=%b expected 0/0", o_valid, o_busy); end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_and_wait(0, lat);
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL b2b_first_lat: got %0d expected %0d", lat, LAT); end
        // Request during the DONE cycle is dropped
        set_vec(1);
        vld = 1'b1;
        tick();
        n_cmp++; if (o_overrun !== 1'b1 || o_busy !== 1'b0) begin n_err++; $display("FAIL b2b_done_drop: got overrun=%b busy=%b expected 1/0", o_overrun, o_busy); end
        set_vec(3);
        tick();
        vld = 1'b0;
        n_cmp++; if (o_busy !== 1'b1 || o_overrun !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got busy=%b overrun=%b expected 1/0", o_busy, o_overrun); end
        lat = 1;
        while (o_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL b2b_second_lat: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (o_metricCov !== ecov[3] || o_metricDep !== exp_dep(3) || o_metricHam !== eham[3]) begin
            n_err++; $display("FAIL b2b_result: got %h/%h/%h expected %h/%h/%h", o_metricCov, o_metricDep, o_metricHam, ecov[3], exp_dep(3), eham[3]);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_metrics();
        test_overrun();
        test_reset_mid();
        test_clock_gate();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
